// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment controller: glyph table, FSM states
// and the digit-to-glyph lookup.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } state_t;

  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] GLYPH_DASH  = 8'h02;

  // Segment order {a,b,c,d,e,f,g,dp}, active-high
  localparam logic [7:0] GLYPH_TABLE [16] = '{
    8'hfc, 8'h60, 8'hda, 8'hf2, 8'h66, 8'hb6, 8'hbe, 8'he0,
    8'hfe, 8'hf6, 8'hee, 8'h3e, 8'h9c, 8'h7a, 8'h9e, 8'h8e
  };

  function automatic logic [7:0] digit_to_glyph(input logic [3:0] digit);
    return GLYPH_TABLE[digit];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter, one input bit per clock. The first
// iteration happens on the start edge so the result is ready NUM_WIDTH-1 edges later.
module bin2bcd_seq #(
  parameter int NUM_WIDTH = 24,
  parameter int DIGITS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_WIDTH-1:0]  value,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(NUM_WIDTH + 1);

  logic [NUM_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d, src_bcd, adj_bcd;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic                 src_bit, launch;

  assign launch  = start && !busy_q;
  assign src_bcd = launch ? '0 : bcd_q;
  assign src_bit = launch ? value[NUM_WIDTH-1] : shift_q[NUM_WIDTH-1];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj_bcd[gi*4 +: 4] = (src_bcd[gi*4 +: 4] >= 4'd5) ?
                                  src_bcd[gi*4 +: 4] + 4'd3 : src_bcd[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    if (launch) begin
      shift_d = value << 1;
      bcd_d   = {adj_bcd[BCD_W-2:0], src_bit};
      cnt_d   = CNT_W'(1);
      ovf_d   = 1'b0;
      busy_d  = (NUM_WIDTH > 1);
      done_d  = (NUM_WIDTH == 1);
    end else if (busy_q) begin
      shift_d = shift_q << 1;
      bcd_d   = {adj_bcd[BCD_W-2:0], src_bit};
      cnt_d   = cnt_q + 1'b1;
      // A bit leaving the top digit means the value needs more digits
      ovf_d   = ovf_q | adj_bcd[BCD_W-1];
      if (cnt_q == CNT_W'(NUM_WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit seven-segment controller: load handshake, decimal/hex conversion,
// atomic display commit and time-multiplexed scan onto two segment buses.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_WIDTH  = 24,
  parameter int DIGITS     = 8,
  parameter int GROUP_SIZE = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [NUM_WIDTH-1:0]  num,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [7:0]            seg_lo,
  output logic [7:0]            seg_hi,
  output logic [DIGITS-1:0]     an,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int DISP_W = DIGITS * 4;
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int PRE_W  = $clog2(SCAN_DIV);

  state_t                      state_q;
  logic [NUM_WIDTH-1:0]        num_q;
  logic                        hex_q, ovf_q, done_q, busy_q, ready_q;
  logic [DISP_W-1:0]           disp_q, conv_bcd, hex_val;
  logic [NUM_WIDTH+DISP_W-1:0] num_ext;
  logic                        accept, conv_start, conv_busy, conv_done, conv_ovf, hex_ovf;

  assign accept     = load_valid && ready_q;
  assign conv_start = accept && !hex_mode;
  assign num_ext    = {{DISP_W{1'b0}}, num_q};
  assign hex_val    = num_ext[DISP_W-1:0];
  assign hex_ovf    = (num_ext >> DISP_W) != '0;

  bin2bcd_seq #(
    .NUM_WIDTH (NUM_WIDTH),
    .DIGITS    (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .value (num),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      hex_q   <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          num_q   <= num;
          hex_q   <= hex_mode;
          ready_q <= 1'b0;
          busy_q  <= !hex_mode;
          state_q <= hex_mode ? ST_COMMIT : ST_CONV;
        end
        ST_CONV: if (conv_done) begin
          busy_q  <= 1'b0;
          state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          disp_q  <= hex_q ? hex_val : conv_bcd;
          ovf_q   <= hex_q ? hex_ovf : conv_ovf;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d, upper_zero;
  logic [7:0]        seg_lo_q, seg_lo_d, seg_hi_q, seg_hi_d, glyph;
  logic [3:0]        cur_digit;

  // upper_zero[i]: digit i and everything above it is zero
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
      assign upper_zero[gi] = (disp_q[DISP_W-1:gi*4] == '0);
    end
  endgenerate

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    cur_digit = disp_q[{idx_q, 2'b00} +: 4];
    if (ovf_q)
      glyph = GLYPH_DASH;
    else if (blank_lz && idx_q != '0 && upper_zero[idx_q])
      glyph = GLYPH_BLANK;
    else
      glyph = digit_to_glyph(cur_digit);
    an_d     = '0;
    seg_lo_d = '0;
    seg_hi_d = '0;
    if (enable) begin
      an_d = DIGITS'(1) << idx_q;
      if (32'(idx_q) < GROUP_SIZE) seg_lo_d = glyph;
      else                         seg_hi_d = glyph;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q    <= '0;
      idx_q    <= '0;
      an_q     <= '0;
      seg_lo_q <= '0;
      seg_hi_q <= '0;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_lo_q <= seg_lo_d;
      seg_hi_q <= seg_hi_d;
    end
  end

  assign load_ready = ready_q;
  assign busy       = busy_q | conv_busy;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign an         = an_q;
  assign seg_lo     = seg_lo_q;
  assign seg_hi     = seg_hi_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: random and directed loads checked
// against a decimal/hex digit model and an observed scan of the display.
module tb_seg_display_ctrl;

  localparam int SD = 4;
  localparam logic [7:0] GL [16] = '{
    8'hfc, 8'h60, 8'hda, 8'hf2, 8'h66, 8'hb6, 8'hbe, 8'he0,
    8'hfe, 8'hf6, 8'hee, 8'h3e, 8'h9c, 8'h7a, 8'h9e, 8'h8e
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default-geometry instance
  logic        lv0 = 1'b0, hm0 = 1'b0, blz0 = 1'b0, en0 = 1'b1;
  logic [23:0] num0 = '0;
  logic        rdy0, busy0, done0, ovf0;
  logic [7:0]  lo0, hi0, an0;

  // Small instance for decimal overflow
  logic        lv1 = 1'b0, hm1 = 1'b0, blz1 = 1'b0, en1 = 1'b1;
  logic [15:0] num1 = '0;
  logic        rdy1, busy1, done1, ovf1;
  logic [7:0]  lo1, hi1;
  logic [3:0]  an1;

  seg_display_ctrl #(.SCAN_DIV(SD)) dut0 (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(rdy0), .num(num0),
    .hex_mode(hm0), .blank_lz(blz0), .enable(en0), .seg_lo(lo0), .seg_hi(hi0),
    .an(an0), .busy(busy0), .done(done0), .overflow(ovf0));

  seg_display_ctrl #(.NUM_WIDTH(16), .DIGITS(4), .SCAN_DIV(SD)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(rdy1), .num(num1),
    .hex_mode(hm1), .blank_lz(blz1), .enable(en1), .seg_lo(lo1), .seg_hi(hi1),
    .an(an1), .busy(busy1), .done(done1), .overflow(ovf1));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: digits by plain arithmetic, then blanking/overflow rules
  function automatic logic [127:0] model_glyphs(input longint v, input bit hex, input bit blz,
                                                input int nd, output bit ovf);
    int dig[16];
    int msd = 0;
    longint lim = 1;
    logic [127:0] g = '0;
    for (int i = 0; i < nd; i++) begin
      dig[i] = hex ? int'((v >> (4 * i)) & 64'd15) : int'((v / lim) % 64'd10);
      lim = lim * 10;
      if (dig[i] != 0) msd = i;
    end
    ovf = hex ? ((v >> (4 * nd)) != 0) : (v >= lim);
    for (int i = 0; i < nd; i++)
      g[i*8 +: 8] = ovf ? 8'h02 : ((blz && i > msd) ? 8'h00 : GL[dig[i]]);
    return g;
  endfunction

  // Watch one full scan period and compare every digit's glyph
  task automatic scan_check(input int inst, input logic [127:0] exp_g, input string tag);
    int nd = (inst == 0) ? 8 : 4;
    logic [127:0] got = '0;
    logic [15:0] seen = '0;
    logic [15:0] a;
    logic [7:0] lo, hi;
    int prev = -1;
    int cur;
    @(negedge clk);
    for (int c = 0; c < nd * SD + 8; c++) begin
      @(negedge clk);
      a  = (inst == 0) ? {8'h00, an0} : {12'h000, an1};
      lo = (inst == 0) ? lo0 : lo1;
      hi = (inst == 0) ? hi0 : hi1;
      check({tag, " an_onehot"}, 64'($countones(a)), 64'd1);
      if ($countones(a) == 1) begin
        cur = 0;
        for (int i = 0; i < 16; i++) if (a[i]) cur = i;
        if (cur < 4) begin
          check({tag, " seg_hi_idle"}, 64'(hi), 64'd0);
          got[cur*8 +: 8] = lo;
        end else begin
          check({tag, " seg_lo_idle"}, 64'(lo), 64'd0);
          got[cur*8 +: 8] = hi;
        end
        if (prev >= 0 && cur != prev)
          check({tag, " scan_order"}, 64'(cur), 64'((prev + 1) % nd));
        prev = cur;
        seen[cur] = 1'b1;
      end
    end
    for (int i = 0; i < nd; i++) begin
      check($sformatf("%s digit%0d_seen", tag, i), 64'(seen[i]), 64'd1);
      check($sformatf("%s digit%0d", tag, i), 64'(got[i*8 +: 8]), 64'(exp_g[i*8 +: 8]));
    end
  endtask

  typedef struct {
    logic [127:0] g;
    bit           ovf;
    bit           hex;
    int           lat;
    int           acc_cyc;
    longint       v;
  } exp_t;

  exp_t sb[$];
  int pushed = 0;
  int checked = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("done_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
          check("overflow", 64'(ovf0), 64'(e.ovf));
          check("ready_at_done", 64'(rdy0), 64'd1);
          check("busy_at_done", 64'(busy0), 64'd0);
          $display("txn value=%06h hex=%0b latency=%0d overflow=%0b", e.v, e.hex, cyc - e.acc_cyc, ovf0);
          @(negedge clk);
          check("done_pulse_width", 64'(done0), 64'd0);
          scan_check(0, e.g, "dut0");
          checked++;
        end
      end
    end
  end

  task automatic issue0(input logic [23:0] v, input bit hex, input bit blz);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (rdy0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_load", 64'(rdy0), 64'd1);
    num0 = v; hm0 = hex; blz0 = blz; lv0 = 1'b1;
    @(posedge clk); #1;
    lv0 = 1'b0;
    num0 = 24'($urandom);
    hm0 = 1'($urandom);
    e.g = model_glyphs(longint'(v), hex, blz, 8, e.ovf);
    e.hex = hex;
    e.lat = hex ? 1 : 25;
    e.acc_cyc = cyc;
    e.v = longint'(v);
    sb.push_back(e);
    pushed++;
  endtask

  task automatic wait_checked();
    int n = 0;
    while (checked != pushed && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("transaction_completed", 64'(checked), 64'(pushed));
  endtask

  task automatic load1(input logic [15:0] v, input string tag);
    logic [127:0] g;
    bit ovf;
    int n = 0;
    int acc;
    @(negedge clk);
    check({tag, " ready"}, 64'(rdy1), 64'd1);
    num1 = v; hm1 = 1'b0; lv1 = 1'b1;
    @(posedge clk); #1;
    lv1 = 1'b0;
    acc = cyc;
    while (done1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(cyc - acc), 64'd17);
    g = model_glyphs(longint'(v), 1'b0, 1'b0, 4, ovf);
    check({tag, " overflow"}, 64'(ovf1), 64'(ovf));
    $display("txn dut1 value=%0d latency=%0d overflow=%0b", v, cyc - acc, ovf1);
    scan_check(1, g, tag);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [23:0] bnd [4];
    logic [23:0] v;
    logic [7:0] a_before;
    int cls;
    bit o;
    bnd[0] = 24'd0; bnd[1] = 24'hFFFFFF; bnd[2] = 24'd9999999; bnd[3] = 24'd1;

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset an", 64'(an0), 64'd0);
    check("reset seg_lo", 64'(lo0), 64'd0);
    check("reset seg_hi", 64'(hi0), 64'd0);
    check("reset busy", 64'(busy0), 64'd0);
    check("reset done", 64'(done0), 64'd0);
    check("reset overflow", 64'(ovf0), 64'd0);
    check("reset load_ready", 64'(rdy0), 64'd1);
    check("reset dut1 an", 64'(an1), 64'd0);
    rst = 1'b1;

    issue0(24'd1234567, 1'b0, 1'b1); wait_checked();
    issue0(24'hABCDEF, 1'b1, 1'b0);   wait_checked();
    issue0(24'd0, 1'b0, 1'b1);        wait_checked();
    issue0(24'hFFFFFF, 1'b0, 1'b0);   wait_checked();

    for (int k = 0; k < 14; k++) begin
      cls = int'($urandom_range(0, 3));
      case (cls)
        0:       v = 24'($urandom_range(0, 99));
        1:       v = 24'($urandom);
        2:       v = bnd[$urandom_range(0, 3)];
        default: v = 24'($urandom_range(0, 9999999));
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue0(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_checked();
    end

    // A second request while converting must be ignored
    issue0(24'd42, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    num0 = 24'd7; hm0 = 1'b1; lv0 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ready_in_conv", 64'(rdy0), 64'd0);
      check("busy_in_conv", 64'(busy0), 64'd1);
    end
    lv0 = 1'b0;
    wait_checked();

    // Disable for one scan period; the index must keep advancing meanwhile
    issue0(24'h13579B, 1'b1, 1'b0);
    wait_checked();
    @(negedge clk);
    a_before = an0;
    en0 = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("dark an", 64'(an0), 64'd0);
      check("dark seg_lo", 64'(lo0), 64'd0);
      check("dark seg_hi", 64'(hi0), 64'd0);
    end
    repeat (10) @(negedge clk);
    en0 = 1'b1;
    repeat (2) @(negedge clk);
    check("resume_index", 64'(an0), 64'(a_before));
    scan_check(0, model_glyphs(64'h13579B, 1'b1, 1'b0, 8, o), "reenable");

    load1(16'd12345, "dut1_ovf");
    load1(16'd9999, "dut1_fit");

    // Reset in the middle of a conversion
    issue0(24'd8765432, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midconv an", 64'(an0), 64'd0);
    check("midconv seg_lo", 64'(lo0), 64'd0);
    check("midconv seg_hi", 64'(hi0), 64'd0);
    check("midconv busy", 64'(busy0), 64'd0);
    check("midconv done", 64'(done0), 64'd0);
    check("midconv overflow", 64'(ovf0), 64'd0);
    check("midconv load_ready", 64'(rdy0), 64'd1);
    sb.delete();
    pushed = checked;
    blz0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    scan_check(0, model_glyphs(64'd0, 1'b0, 1'b0, 8, o), "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
